irq_request_latch: RTL

//  Front end of the 4-line interrupt path. Synchronises raw request lines, edge-detects them and holds

---
 rtl/irq_request_latch.sv | 64 ++++++
 1 files changed

// File: rtl/irq_request_latch.sv
// irq_request_latch: synchronise/edge-detect 4 request lines, latch masked pending bits, present one irq at a time.
// Optional IRQ_LATCH_OVERRUN_EN adds sticky per-line overrun flags with ovr_clr.
module irq_request_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic [3:0] mask,
    output logic [3:0] pend,
    input  logic       enc_v,
    input  logic [1:0] enc_y,
    output logic       irq_valid,
    output logic [1:0] irq_id,
    input  logic       irq_ack
`ifdef IRQ_LATCH_OVERRUN_EN
    ,
    input  logic       ovr_clr,
    output logic [3:0] overrun
`endif
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0][3:0] sync;
    logic [3:0] sync_d, rise, set, clr;
    logic [1:0] id_nxt;
    assign rise = sync[SYNC_STAGES-1] & ~sync_d;
    assign set = rise & mask;
    assign irq_valid = state == PRESENT;
    always_comb begin
        state_nxt = state;
        id_nxt = irq_id;
        clr = 4'b0000;
        if (state == IDLE) begin
            state_nxt = enc_v ? PRESENT : IDLE;
            id_nxt = enc_v ? enc_y : irq_id;
        end else if (irq_ack) begin
            state_nxt = IDLE;
            clr = 4'b0001 << irq_id;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            sync_d <= 4'b0000;
            pend <= 4'b0000;
            state <= IDLE;
            irq_id <= 2'd0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], req_in};
            sync_d <= sync[SYNC_STAGES-1];
            pend <= (pend & ~clr) | set;
            state <= state_nxt;
            irq_id <= id_nxt;
        end
    end
`ifdef IRQ_LATCH_OVERRUN_EN
    // A new edge landing on a still-pending, not-being-cleared line is a lost request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun <= 4'b0000;
        else overrun <= (set & pend & ~clr) | (ovr_clr ? 4'b0000 : overrun);
    end
`endif
endmodule
